// File: rtl/phys_mem_ctrl_pkg.sv
// Memory-map constants, FSM state encodings and the physical address decoder
// for the SRAM/COM memory controller.
package phys_mem_ctrl_pkg;

  localparam int          DATA_W         = 32;
  localparam int          RAM_AW_DEFAULT = 20;
  localparam logic [31:0] COM_DATA_ADDR  = 32'h1FD0_03F8;
  localparam logic [31:0] COM_STAT_ADDR  = 32'h1FD0_03FC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_WRITE_HOLD,
    ST_UART_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_COM_DATA,
    REG_COM_STAT,
    REG_UNMAPPED
  } region_e;

  // Byte-lane bits are ignored; RAM occupies everything below 4 << aw bytes.
  function automatic region_e decode_addr(input logic [31:0] addr, input int aw);
    if (addr[31:2] == COM_DATA_ADDR[31:2]) return REG_COM_DATA;
    if (addr[31:2] == COM_STAT_ADDR[31:2]) return REG_COM_STAT;
    if ((addr >> (aw + 2)) == 32'd0) return REG_RAM;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/phys_mem_ctrl.sv
// Physical memory controller: decodes CPU accesses to SRAM, COM registers or
// unmapped space and sequences the asynchronous SRAM strobes.
//
//   state      | meaning
//   IDLE       | no access since reset; accepts a pending request
//   READ       | ce_n/oe_n low, counting down to the data sample edge
//   WRITE      | ce_n/we_n low, write data driven
//   WRITE_HOLD | we_n released, data held one more cycle
//   UART_WAIT  | waiting for the transmitter to go idle
//   DONE       | last access complete; accepts the next pending request
module phys_mem_ctrl
  import phys_mem_ctrl_pkg::*;
#(
  parameter int RAM_AW  = RAM_AW_DEFAULT,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_is_write,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_busy,
  output logic [RAM_AW-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_start,
  input  logic              uart_tx_busy,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_ready,
  output logic              uart_rx_ack,
  output logic              int_com_req
);

  state_e            state, state_n;
  region_e           cur_region;
  logic [7:0]        cnt;
  logic [31:0]       req_addr, last_addr;
  logic [DATA_W-1:0] req_data, last_data;
  logic              last_wr, last_valid;
  logic              pending, accept, drive;

  // No request strobe: a request is any tuple that differs from the last completed one.
  assign pending    = !last_valid ||
                      ({mem_addr, mem_is_write, mem_data_in} != {last_addr, last_wr, last_data});
  assign accept     = (state == ST_IDLE || state == ST_DONE) && pending;
  assign mem_busy   = pending || !(state == ST_IDLE || state == ST_DONE);
  assign cur_region = decode_addr(mem_addr, RAM_AW);

  assign sram_addr    = req_addr[RAM_AW+1:2];
  assign sram_data    = drive ? req_data : 32'bz;
  assign uart_tx_data = req_data[7:0];
  assign int_com_req  = uart_rx_ready;

  always_comb begin
    state_n       = state;
    sram_ce_n     = 1'b1;
    sram_oe_n     = 1'b1;
    sram_we_n     = 1'b1;
    drive         = 1'b0;
    uart_tx_start = 1'b0;
    uart_rx_ack   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (pending) begin
          case (cur_region)
            REG_RAM:      state_n = mem_is_write ? ST_WRITE : ST_READ;
            REG_COM_DATA: begin
              state_n     = mem_is_write ? ST_UART_WAIT : ST_DONE;
              uart_rx_ack = !mem_is_write && uart_rx_ready;
            end
            default:      state_n = ST_DONE;
          endcase
        end
      end
      ST_READ: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if (cnt == 8'd0) state_n = ST_DONE;
      end
      ST_WRITE: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        drive     = 1'b1;
        if (cnt == 8'd0) state_n = ST_WRITE_HOLD;
      end
      ST_WRITE_HOLD: begin
        sram_ce_n = 1'b0;
        drive     = 1'b1;
        state_n   = ST_DONE;
      end
      ST_UART_WAIT: begin
        if (!uart_tx_busy) begin
          uart_tx_start = 1'b1;
          state_n       = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (rst) begin
      uart_tx_start = 1'b0;
      uart_rx_ack   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= 8'd0;
      req_addr     <= 32'd0;
      req_data     <= '0;
      last_addr    <= 32'd0;
      last_data    <= '0;
      last_wr      <= 1'b0;
      last_valid   <= 1'b0;
      mem_data_out <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        req_addr <= mem_addr;
        req_data <= mem_data_in;
        cnt      <= mem_is_write ? 8'(WR_WAIT - 1) : 8'(RD_WAIT - 1);
        if (!mem_is_write) begin
          case (cur_region)
            REG_COM_DATA: mem_data_out <= uart_rx_ready ? {24'd0, uart_rx_data} : '0;
            REG_COM_STAT: mem_data_out <= {30'd0, uart_rx_ready, ~uart_tx_busy};
            REG_UNMAPPED: mem_data_out <= '0;
            default:      ;
          endcase
        end
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (state == ST_READ && cnt == 8'd0) mem_data_out <= sram_data;
      // Direct-to-DONE accepts record the live tuple; multi-cycle ops record the latched one.
      if (state_n == ST_DONE && (state != ST_DONE || accept)) begin
        last_valid <= 1'b1;
        last_addr  <= accept ? mem_addr     : req_addr;
        last_data  <= accept ? mem_data_in  : req_data;
        last_wr    <= accept ? mem_is_write : (state == ST_WRITE_HOLD || state == ST_UART_WAIT);
      end
    end
  end

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Directed bench for phys_mem_ctrl with a small behavioural SRAM model.
module tb_phys_mem_ctrl;

  localparam logic [31:0] A_COM_DATA = 32'h1FD0_03F8;
  localparam logic [31:0] A_COM_STAT = 32'h1FD0_03FC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = 32'h8000_0004;
  logic [31:0] mem_data_in = 32'd0;
  logic        mem_is_write = 1'b0;
  logic [31:0] mem_data_out;
  logic        mem_busy;
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy = 1'b0;
  logic [7:0]  uart_rx_data = 8'd0;
  logic        uart_rx_ready = 1'b0;
  logic        uart_rx_ack;
  logic        int_com_req;

  logic [31:0] sram_mem [0:255];

  int n_cmp = 0;
  int n_err = 0;
  int busy_cyc, ce_cyc, oe_cyc, we_cyc, hold_cyc, start_cyc, ack_cyc, start_at;
  logic [7:0] tx_seen;
  logic timeout;

  always #5 clk = ~clk;

  phys_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_is_write(mem_is_write),
    .mem_data_out(mem_data_out), .mem_busy(mem_busy),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready), .uart_rx_ack(uart_rx_ack),
    .int_com_req(int_com_req)
  );

  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 32'bz;

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr[7:0]] <= sram_data;

  // Present a tuple and step until busy drops, tallying strobes per busy cycle.
  task automatic run_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input int release_at, input int change_at, input logic [31:0] alt_a);
    mem_addr = a; mem_is_write = w; mem_data_in = d;
    busy_cyc = 0; ce_cyc = 0; oe_cyc = 0; we_cyc = 0; hold_cyc = 0;
    start_cyc = 0; ack_cyc = 0; start_at = -1; tx_seen = 8'd0; timeout = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc == release_at) uart_tx_busy = 1'b0;
      if (cyc == change_at) mem_addr = alt_a;
      #1;
      if (!mem_busy) break;
      if (cyc >= 60) begin timeout = 1'b1; break; end
      busy_cyc++;
      if (!sram_ce_n) ce_cyc++;
      if (!sram_ce_n && !sram_oe_n) oe_cyc++;
      if (!sram_ce_n && !sram_we_n) we_cyc++;
      if (!sram_ce_n && sram_we_n && sram_oe_n) hold_cyc++;
      if (uart_tx_start) begin start_cyc++; start_at = cyc; tx_seen = uart_tx_data; end
      if (uart_rx_ack) ack_cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (mem_data_out !== 32'd0) begin n_err++; $display("FAIL reset_data_out got %h want 0", mem_data_out); end
    n_cmp++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin n_err++; $display("FAIL reset_strobes got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    n_cmp++; if ({uart_tx_start, uart_rx_ack} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got %b want 00", {uart_tx_start, uart_rx_ack}); end
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_busy !== 1'b1) begin n_err++; $display("FAIL reset_first_busy got %b want 1", mem_busy); end
    @(posedge clk); #1;
    n_cmp++; if (mem_busy !== 1'b0) begin n_err++; $display("FAIL reset_settle_busy got %b want 0", mem_busy); end
  endtask

  task automatic test_ram_read;
    run_access(32'h0000_0010, 1'b0, 32'd0, -1, -1, 32'd0);
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL rd_timeout got %b want 0", timeout); end
    n_cmp++; if (busy_cyc != 3) begin n_err++; $display("FAIL rd_busy got %0d want 3", busy_cyc); end
    n_cmp++; if (oe_cyc != 2) begin n_err++; $display("FAIL rd_oe got %0d want 2", oe_cyc); end
    n_cmp++; if (mem_data_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data got %h want deadbeef", mem_data_out); end
  endtask

  task automatic test_ram_write;
    run_access(32'h0000_0020, 1'b1, 32'h1234_5678, -1, -1, 32'd0);
    n_cmp++; if (busy_cyc != 4) begin n_err++; $display("FAIL wr_busy got %0d want 4", busy_cyc); end
    n_cmp++; if (we_cyc != 2) begin n_err++; $display("FAIL wr_we got %0d want 2", we_cyc); end
    n_cmp++; if (hold_cyc != 1) begin n_err++; $display("FAIL wr_hold got %0d want 1", hold_cyc); end
    n_cmp++; if (sram_mem[8] !== 32'h1234_5678) begin n_err++; $display("FAIL wr_mem got %h want 12345678", sram_mem[8]); end
    run_access(32'h0000_0020, 1'b0, 32'd0, -1, -1, 32'd0);
    n_cmp++; if (busy_cyc != 3) begin n_err++; $display("FAIL rb_busy got %0d want 3", busy_cyc); end
    n_cmp++; if (mem_data_out !== 32'h1234_5678) begin n_err++; $display("FAIL rb_data got %h want 12345678", mem_data_out); end
  endtask

  task automatic test_unmapped;
    run_access(32'h8000_0000, 1'b0, 32'd0, -1, -1, 32'd0);
    n_cmp++; if (busy_cyc != 1) begin n_err++; $display("FAIL um_rd_busy got %0d want 1", busy_cyc); end
    n_cmp++; if (mem_data_out !== 32'd0) begin n_err++; $display("FAIL um_rd_data got %h want 0", mem_data_out); end
    run_access(32'h8000_0000, 1'b1, 32'h0000_FFFF, -1, -1, 32'd0);
    n_cmp++; if (busy_cyc != 1) begin n_err++; $display("FAIL um_wr_busy got %0d want 1", busy_cyc); end
    n_cmp++; if (ce_cyc != 0) begin n_err++; $display("FAIL um_wr_ce got %0d want 0", ce_cyc); end
    n_cmp++; if (start_cyc != 0) begin n_err++; $display("FAIL um_wr_txstart got %0d want 0", start_cyc); end
  endtask

  task automatic test_uart_rx;
    uart_rx_data = 8'h5A; uart_rx_ready = 1'b1;
    #1;
    n_cmp++; if (int_com_req !== 1'b1) begin n_err++; $display("FAIL int_req_hi got %b want 1", int_com_req); end
    run_access(A_COM_STAT, 1'b0, 32'd0, -1, -1, 32'd0);
    n_cmp++; if (mem_data_out !== 32'h3) begin n_err++; $display("FAIL stat_data got %h want 3", mem_data_out); end
    n_cmp++; if (ack_cyc != 0) begin n_err++; $display("FAIL stat_ack got %0d want 0", ack_cyc); end
    run_access(A_COM_DATA, 1'b0, 32'd0, -1, -1, 32'd0);
    n_cmp++; if (busy_cyc != 1) begin n_err++; $display("FAIL rx_busy got %0d want 1", busy_cyc); end
    n_cmp++; if (mem_data_out !== 32'h5A) begin n_err++; $display("FAIL rx_data got %h want 5a", mem_data_out); end
    n_cmp++; if (ack_cyc != 1) begin n_err++; $display("FAIL rx_ack got %0d want 1", ack_cyc); end
    uart_rx_ready = 1'b0;
    #1;
    n_cmp++; if (int_com_req !== 1'b0) begin n_err++; $display("FAIL int_req_lo got %b want 0", int_com_req); end
    run_access(A_COM_DATA, 1'b0, 32'd1, -1, -1, 32'd0);
    n_cmp++; if (mem_data_out !== 32'd0) begin n_err++; $display("FAIL rx_empty_data got %h want 0", mem_data_out); end
    n_cmp++; if (ack_cyc != 0) begin n_err++; $display("FAIL rx_empty_ack got %0d want 0", ack_cyc); end
  endtask

  task automatic test_uart_tx;
    uart_tx_busy = 1'b1;
    run_access(A_COM_DATA, 1'b1, 32'h0000_0041, 5, -1, 32'd0);
    n_cmp++; if (start_cyc != 1) begin n_err++; $display("FAIL tx_start_count got %0d want 1", start_cyc); end
    n_cmp++; if (start_at != 5) begin n_err++; $display("FAIL tx_start_cycle got %0d want 5", start_at); end
    n_cmp++; if (tx_seen !== 8'h41) begin n_err++; $display("FAIL tx_data got %h want 41", tx_seen); end
    n_cmp++; if (busy_cyc != 6) begin n_err++; $display("FAIL tx_busy_cycles got %0d want 6", busy_cyc); end
  endtask

  task automatic test_back_to_back;
    run_access(32'h0000_0010, 1'b0, 32'd0, -1, 1, 32'h0000_0014);
    n_cmp++; if (busy_cyc != 6) begin n_err++; $display("FAIL b2b_busy got %0d want 6", busy_cyc); end
    n_cmp++; if (oe_cyc != 4) begin n_err++; $display("FAIL b2b_oe got %0d want 4", oe_cyc); end
    n_cmp++; if (mem_data_out !== 32'hCAFE_F00D) begin n_err++; $display("FAIL b2b_data got %h want cafef00d", mem_data_out); end
    @(posedge clk); #1;
    n_cmp++; if (mem_busy !== 1'b0 || sram_oe_n !== 1'b1) begin n_err++; $display("FAIL coalesce got busy=%b oe_n=%b want 0 1", mem_busy, sram_oe_n); end
  endtask

  task automatic test_reset_mid_write;
    mem_addr = 32'h0000_0040; mem_is_write = 1'b1; mem_data_in = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    n_cmp++; if (sram_we_n !== 1'b0) begin n_err++; $display("FAIL mw_in_write got we_n=%b want 0", sram_we_n); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({sram_we_n, sram_ce_n} !== 2'b11) begin n_err++; $display("FAIL mw_strobes got %b want 11", {sram_we_n, sram_ce_n}); end
    n_cmp++; if (mem_data_out !== 32'd0) begin n_err++; $display("FAIL mw_data_out got %h want 0", mem_data_out); end
    rst = 1'b0;
    run_access(32'h0000_0040, 1'b1, 32'hA5A5_A5A5, -1, -1, 32'd0);
    n_cmp++; if (busy_cyc != 4) begin n_err++; $display("FAIL mw_reissue_busy got %0d want 4", busy_cyc); end
    n_cmp++; if (we_cyc != 2) begin n_err++; $display("FAIL mw_reissue_we got %0d want 2", we_cyc); end
    n_cmp++; if (sram_mem[16] !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mw_mem got %h want a5a5a5a5", sram_mem[16]); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 32'd0;
    sram_mem[4] = 32'hDEAD_BEEF;
    sram_mem[5] = 32'hCAFE_F00D;
    test_reset;
    test_ram_read;
    test_ram_write;
    test_unmapped;
    test_uart_rx;
    test_uart_tx;
    test_back_to_back;
    test_reset_mid_write;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
